// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris command scheduler: repeat-FSM states,
// default timing parameters and the fixed command priority order.
package tetris_pkg;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_HOLD   = 2'd1,
    H_REPEAT = 2'd2
  } h_state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } hdir_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_ROTATE = 2'd1,
    CMD_LEFT   = 2'd2,
    CMD_RIGHT  = 2'd3
  } cmd_t;

  localparam int DEF_TICK_DIV   = 8;
  localparam int DEF_REPEAT_DLY = 3;

  localparam int   CMD_PRIO_N = 3;
  localparam cmd_t CMD_PRIO [0:CMD_PRIO_N-1] = '{CMD_ROTATE, CMD_LEFT, CMD_RIGHT};

  // req is indexed by cmd_t; the highest-priority requested command wins.
  function automatic cmd_t pick_cmd(input logic [3:0] req);
    cmd_t sel;
    sel = CMD_NONE;
    for (int i = CMD_PRIO_N - 1; i >= 0; i--) begin
      if (req[CMD_PRIO[i]]) sel = CMD_PRIO[i];
    end
    return sel;
  endfunction

endpackage

// File: rtl/tetris_edge_det.sv
// Registered rising-edge detector: remembers last sampled button level and
// flags a low-to-high transition on the current cycle.
module tetris_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/tetris_cmd_sched.sv
// Step generator and button command scheduler for the 6x6 Tetris core,
// with pending-press capture and horizontal auto-repeat.
module tetris_cmd_sched
  import tetris_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic game_over,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  output logic step,
  output logic cmd_left,
  output logic cmd_right,
  output logic cmd_rotate
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;
  logic             step_edge;

  logic rise_left, rise_right, rise_rotate;
  logic pend_left, pend_right, pend_rotate;

  h_state_t h_state, h_state_n;
  hdir_t    hdir, hdir_n;
  logic [3:0] hold_cnt, hold_cnt_n;
  logic     hdir_btn;

  logic rep_left, rep_right;
  cmd_t sel;
  logic take_left, take_right, take_rotate;

  tetris_edge_det u_ed_left   (.clk(clk), .rst_n(rst_n), .btn(btn_left),   .rise(rise_left));
  tetris_edge_det u_ed_right  (.clk(clk), .rst_n(rst_n), .btn(btn_right),  .rise(rise_right));
  tetris_edge_det u_ed_rotate (.clk(clk), .rst_n(rst_n), .btn(btn_rotate), .rise(rise_rotate));

  assign wrap      = (div_cnt == CNT_W'(TICK_DIV - 1));
  assign step_edge = en & ~game_over & wrap;
  assign hdir_btn  = (hdir == DIR_LEFT) ? btn_left : btn_right;

  // Command choice uses only state held before the edge, so a press landing
  // on a step edge is served on the following step.
  always_comb begin
    rep_left    = (h_state == H_REPEAT) && (hdir == DIR_LEFT);
    rep_right   = (h_state == H_REPEAT) && (hdir == DIR_RIGHT);
    sel         = pick_cmd({pend_right | rep_right, pend_left | rep_left, pend_rotate, 1'b0});
    take_rotate = step_edge && (sel == CMD_ROTATE);
    take_left   = step_edge && (sel == CMD_LEFT);
    take_right  = step_edge && (sel == CMD_RIGHT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      step        <= 1'b0;
      cmd_left    <= 1'b0;
      cmd_right   <= 1'b0;
      cmd_rotate  <= 1'b0;
      pend_left   <= 1'b0;
      pend_right  <= 1'b0;
      pend_rotate <= 1'b0;
    end else if (game_over) begin
      div_cnt     <= '0;
      step        <= 1'b0;
      cmd_left    <= 1'b0;
      cmd_right   <= 1'b0;
      cmd_rotate  <= 1'b0;
      pend_left   <= 1'b0;
      pend_right  <= 1'b0;
      pend_rotate <= 1'b0;
    end else begin
      if (en) div_cnt <= wrap ? '0 : div_cnt + CNT_W'(1);
      step        <= step_edge;
      cmd_left    <= take_left;
      cmd_right   <= take_right;
      cmd_rotate  <= take_rotate;
      // A new press on the consuming edge keeps the bit set.
      pend_left   <= rise_left   | (pend_left   & ~take_left);
      pend_right  <= rise_right  | (pend_right  & ~take_right);
      pend_rotate <= rise_rotate | (pend_rotate & ~take_rotate);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state  <= H_IDLE;
      hdir     <= DIR_LEFT;
      hold_cnt <= 4'd0;
    end else begin
      h_state  <= h_state_n;
      hdir     <= hdir_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  // Hold counts steps with the button down; the step that finds the count
  // already at REPEAT_DLY arms repeat, and later steps emit it.
  always_comb begin
    h_state_n  = h_state;
    hdir_n     = hdir;
    hold_cnt_n = hold_cnt;
    if (game_over) begin
      h_state_n = H_IDLE;
    end else begin
      case (h_state)
        H_IDLE: begin
          if (rise_left || rise_right) begin
            h_state_n  = H_HOLD;
            hdir_n     = rise_left ? DIR_LEFT : DIR_RIGHT;
            hold_cnt_n = 4'd0;
          end
        end
        H_HOLD: begin
          if (!hdir_btn) begin
            h_state_n = H_IDLE;
          end else if (step_edge) begin
            if (hold_cnt == 4'(REPEAT_DLY)) h_state_n = H_REPEAT;
            else                            hold_cnt_n = hold_cnt + 4'd1;
          end
        end
        H_REPEAT: begin
          if (!hdir_btn) h_state_n = H_IDLE;
        end
        default: h_state_n = H_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// Self-checking bench for tetris_cmd_sched: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_tetris_cmd_sched;

  localparam int TD = 4;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic game_over = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_rotate = 1'b0;
  logic step, cmd_left, cmd_right, cmd_rotate;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int cyc = 0;

  // Behavioural model: qualifying-edge count, pending presses {rot,left,right},
  // and hold tracking as "steps seen while the direction button is held".
  int       m_q;
  int       m_hsteps;
  bit       m_hold;
  bit       m_hdir;
  bit [2:0] m_prev;
  bit [2:0] m_pend;
  logic [3:0] m_out;

  tetris_cmd_sched #(.TICK_DIV(TD), .REPEAT_DLY(RD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .game_over(game_over),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .step(step), .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rotate(cmd_rotate)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dutOut();
    return {step, cmd_rotate, cmd_left, cmd_right};
  endfunction

  task automatic modelReset();
    m_q = 0; m_hsteps = 0; m_hold = 0; m_hdir = 0;
    m_prev = '0; m_pend = '0; m_out = '0;
  endtask

  task automatic modelEdge();
    bit [2:0] btn, rise;
    bit is_step, rep_l, rep_r, hbtn;
    btn = {btn_rotate, btn_left, btn_right};
    if (!rst_n) begin
      modelReset();
      return;
    end
    rise  = btn & ~m_prev;
    m_out = '0;
    if (game_over) begin
      m_q = 0; m_pend = '0; m_hold = 0; m_prev = btn;
      return;
    end
    is_step = 0;
    if (en) begin
      m_q = (m_q + 1) % TD;
      is_step = (m_q == 0);
    end
    rep_l = m_hold && !m_hdir && (m_hsteps >= RD + 1);
    rep_r = m_hold &&  m_hdir && (m_hsteps >= RD + 1);
    if (is_step) begin
      m_out[3] = 1'b1;
      if (m_pend[2])               begin m_out[2] = 1'b1; m_pend[2] = 1'b0; end
      else if (m_pend[1] || rep_l) begin m_out[1] = 1'b1; m_pend[1] = 1'b0; end
      else if (m_pend[0] || rep_r) begin m_out[0] = 1'b1; m_pend[0] = 1'b0; end
    end
    m_pend = m_pend | rise;
    hbtn = m_hdir ? btn[0] : btn[1];
    if (m_hold) begin
      if (!hbtn) m_hold = 0;
      else if (is_step) m_hsteps++;
    end else if (rise[1] || rise[0]) begin
      m_hold = 1; m_hdir = !rise[1]; m_hsteps = 0;
    end
    m_prev = btn;
  endtask

  task automatic checkOutput(input string name);
    tests++;
    if (dutOut() !== m_out) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d edge=%0d got {step,rot,left,right}=%b expected %b",
               name, cyc, edge_no, dutOut(), m_out);
    end
  endtask

  task automatic checkLit(input string name, input logic [3:0] lit);
    tests++;
    if (dutOut() !== lit) begin
      fails++;
      $display("[TB] FAIL %s dut got %b expected %b", name, dutOut(), lit);
    end
    tests++;
    if (m_out !== lit) begin
      fails++;
      $display("[TB] FAIL %s model got %b expected %b", name, m_out, lit);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    edge_no++;
    cyc++;
    @(negedge clk);
    checkOutput("cycle");
  endtask

  task automatic advanceTo(input int e);
    while (edge_no < e) cycle();
  endtask

  task automatic doReset();
    rst_n = 1'b0; en = 1'b1; game_over = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    modelReset();
    repeat (2) cycle();
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic applyStimulus();
    if (!rst_n) begin
      rst_n = 1'b1;
    end else if ($urandom_range(399, 0) == 0) begin
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
    end
    if ($urandom_range(15, 0) == 0) btn_left   = ~btn_left;
    if ($urandom_range(15, 0) == 0) btn_right  = ~btn_right;
    if ($urandom_range(7, 0)  == 0) btn_rotate = ~btn_rotate;
    if (en) begin
      if ($urandom_range(24, 0) == 0) en = 1'b0;
    end else if ($urandom_range(3, 0) == 0) en = 1'b1;
    if (game_over) begin
      if ($urandom_range(5, 0) == 0) game_over = 1'b0;
    end else if ($urandom_range(149, 0) == 0) game_over = 1'b1;
  endtask

  initial begin
    modelReset();

    // Reset state
    #2;
    checkLit("reset_state", 4'b0000);

    // Free-running steps
    doReset();
    advanceTo(4);  checkLit("idle_step4", 4'b1000);
    advanceTo(8);  checkLit("idle_step8", 4'b1000);
    advanceTo(12); checkLit("idle_step12", 4'b1000);

    // Single left tap
    doReset();
    btn_left = 1'b1; cycle(); btn_left = 1'b0;
    advanceTo(4);  checkLit("tap_left4", 4'b1010);
    advanceTo(8);  checkLit("tap_left8", 4'b1000);

    // Rotate and left together
    doReset();
    btn_rotate = 1'b1; btn_left = 1'b1; cycle();
    btn_rotate = 1'b0; btn_left = 1'b0;
    advanceTo(4);  checkLit("prio_rot4", 4'b1100);
    advanceTo(8);  checkLit("prio_left8", 4'b1010);

    // Right held: tap, hold delay, then auto-repeat
    doReset();
    btn_right = 1'b1;
    advanceTo(4);  checkLit("hold_r4", 4'b1001);
    advanceTo(8);  checkLit("hold_r8", 4'b1000);
    advanceTo(12); checkLit("hold_r12", 4'b1000);
    advanceTo(16); checkLit("hold_r16", 4'b1001);
    advanceTo(20); checkLit("hold_r20", 4'b1001);
    btn_right = 1'b0;
    cycle();

    // Game over clears pending and restarts the divider
    doReset();
    btn_left = 1'b1; cycle(); btn_left = 1'b0;
    advanceTo(2);
    game_over = 1'b1;
    advanceTo(4);  checkLit("go_edge4", 4'b0000);
    advanceTo(8);  checkLit("go_edge8", 4'b0000);
    advanceTo(9);
    game_over = 1'b0;
    advanceTo(13); checkLit("go_step13", 4'b1000);

    // Press landing on a step edge waits for the next step
    doReset();
    advanceTo(3);
    btn_right = 1'b1; cycle(); btn_right = 1'b0;
    checkLit("late_r4", 4'b1000);
    advanceTo(8);  checkLit("late_r8", 4'b1001);

    // Enable low freezes the divider but still captures presses
    doReset();
    en = 1'b0;
    cycle();
    btn_left = 1'b1; cycle(); btn_left = 1'b0;
    advanceTo(5);
    en = 1'b1;
    advanceTo(9);  checkLit("en_step9", 4'b1010);

    // Asynchronous reset during auto-repeat
    doReset();
    btn_right = 1'b1;
    advanceTo(16); checkLit("rst_pre16", 4'b1001);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkLit("rst_async", 4'b0000);
    btn_right = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    edge_no = 0;
    advanceTo(3);  checkLit("rst_after3", 4'b0000);
    advanceTo(4);  checkLit("rst_after4", 4'b1000);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
